key_equation_solver: RTL and testbench

KEY_EQUATION_SOLVER -- requirements
Module: key_equation_solver

---
 rtl/rs_pkg.sv | 17 +
 rtl/gf256_mul.sv | 24 ++
 rtl/key_equation_solver.sv | 178 +++++++++++++++++
 tb/tb_key_equation_solver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared constants and FSM encoding for the RS(255,239) key equation solver.
package rs_pkg;

  // Low byte of the primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D).
  localparam logic [7:0] GF_POLY = 8'h1D;
  localparam int         T       = 8;
  localparam int         TWO_T   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DISC   = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) polynomial-basis multiplier, reduced modulo 0x11D.
module gf256_mul
  import rs_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] sh;

  // Shift-and-add: accumulate a*x^i for each set bit of b, reducing a each step.
  always_comb begin
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY : 8'h00);
    end
    p = acc;
  end

endmodule

// File: rtl/key_equation_solver.sv
// Inversionless Berlekamp-Massey key equation solver for RS(255,239), t=8.
// Loads 16 syndromes, runs 16 fixed DISC/UPDATE iterations, presents the
// gamma-scaled error locator with a one-cycle done pulse.
//
// Handshake: a syndrome byte is transferred on a rising edge where
// S_valid && S_ready; S_ready depends only on state, never on S_valid.
module key_equation_solver
  import rs_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        S_valid,
  input  logic [7:0]  S_in,
  output logic        S_ready,
  output logic [71:0] Sigma,
  output logic [4:0]  L,
  output logic        fail,
  output logic        done,
  output logic [2:0]  dbg_state
);

  state_t      state_q, state_d;
  logic [7:0]  syn_q    [TWO_T];
  logic [7:0]  syn_d    [TWO_T];
  logic [7:0]  lambda_q [T+1];
  logic [7:0]  lambda_d [T+1];
  logic [7:0]  b_q      [T+1];
  logic [7:0]  b_d      [T+1];
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  r_q, r_d;
  logic [7:0]  gamma_q, gamma_d;
  logic [7:0]  delta_q, delta_d;
  logic [4:0]  l_q, l_d;
  logic [4:0]  lout_q, lout_d;
  logic [71:0] sigma_q, sigma_d;
  logic        fail_q, fail_d;

  logic [7:0]  syn_term  [T+1];
  logic [7:0]  disc_prod [T+1];
  logic [7:0]  xb        [T+1];
  logic [7:0]  gl_prod   [T+1];
  logic [7:0]  db_prod   [T+1];
  logic [7:0]  disc_sum;
  logic        accept;
  logic        change;

  // Discrepancy terms lambda_i*S_(r+1-i) and update terms gamma*lambda_i, delta*(xB)_i.
  for (genvar i = 0; i <= T; i++) begin : g_mul
    gf256_mul u_disc (.a(lambda_q[i]), .b(syn_term[i]), .p(disc_prod[i]));
    gf256_mul u_gl   (.a(gamma_q),     .b(lambda_q[i]), .p(gl_prod[i]));
    gf256_mul u_db   (.a(delta_q),     .b(xb[i]),       .p(db_prod[i]));
  end

  // Select syndrome operands for this iteration and form x*B and the discrepancy sum.
  always_comb begin
    disc_sum = 8'h00;
    for (int i = 0; i <= T; i++) begin
      syn_term[i] = (r_q >= 4'(i)) ? syn_q[r_q - 4'(i)] : 8'h00;
      xb[i]       = (i == 0) ? 8'h00 : b_q[(i == 0) ? 0 : i - 1];
      disc_sum    = disc_sum ^ disc_prod[i];
    end
  end

  assign accept = S_valid && S_ready;
  assign change = (delta_q != 8'h00) && ({l_q, 1'b0} <= {2'b00, r_q});

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic: load 16 bytes, then 16 fixed two-cycle iterations.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    if (accept && cnt_q == 4'd15) state_d = DISC;
      DISC:    state_d = UPDATE;
      UPDATE:  state_d = (r_q == 4'd15) ? DONE : DISC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready while collecting syndromes, done for the single DONE cycle.
  always_comb begin
    S_ready   = (state_q == IDLE) || (state_q == LOAD);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // Datapath next-state: syndrome store, BM registers and result registers.
  always_comb begin
    syn_d    = syn_q;
    lambda_d = lambda_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    gamma_d  = gamma_q;
    delta_d  = delta_q;
    l_d      = l_q;
    lout_d   = lout_q;
    sigma_d  = sigma_q;
    fail_d   = fail_q;
    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          syn_d[cnt_q] = S_in;
          cnt_d        = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            for (int i = 0; i <= T; i++) begin
              lambda_d[i] = (i == 0) ? 8'h01 : 8'h00;
              b_d[i]      = (i == 0) ? 8'h01 : 8'h00;
            end
            gamma_d = 8'h01;
            l_d     = 5'd0;
            r_d     = 4'd0;
          end
        end
      end
      DISC: delta_d = disc_sum;
      UPDATE: begin
        for (int i = 0; i <= T; i++) lambda_d[i] = gl_prod[i] ^ db_prod[i];
        if (change) begin
          b_d     = lambda_q;
          l_d     = {1'b0, r_q} + 5'd1 - l_q;
          gamma_d = delta_q;
        end else begin
          b_d = xb;
        end
        r_d = r_q + 4'd1;
        if (r_q == 4'd15) begin
          for (int i = 0; i <= T; i++) sigma_d[8*i +: 8] = lambda_d[i];
          lout_d = l_d;
          fail_d = (l_d > 5'd8);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial syndrome load or iteration.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < TWO_T; i++) syn_q[i] <= 8'h00;
      for (int i = 0; i <= T; i++) begin
        lambda_q[i] <= 8'h00;
        b_q[i]      <= 8'h00;
      end
      cnt_q   <= 4'd0;
      r_q     <= 4'd0;
      gamma_q <= 8'h00;
      delta_q <= 8'h00;
      l_q     <= 5'd0;
      lout_q  <= 5'd0;
      sigma_q <= 72'h0;
      fail_q  <= 1'b0;
    end else begin
      syn_q    <= syn_d;
      lambda_q <= lambda_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      gamma_q  <= gamma_d;
      delta_q  <= delta_d;
      l_q      <= l_d;
      lout_q   <= lout_d;
      sigma_q  <= sigma_d;
      fail_q   <= fail_d;
    end
  end

  assign Sigma = sigma_q;
  assign L     = lout_q;
  assign fail  = fail_q;

endmodule

// File: tb/tb_key_equation_solver.sv
// Self-checking bench for key_equation_solver: directed syndrome vectors with
// known locators plus randomized vectors checked against a log-table BM model.
module tb_key_equation_solver;
  import rs_pkg::*;

  localparam int LAT = 32;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Reset;
  logic        S_valid;
  logic [7:0]  S_in;
  logic        S_ready;
  logic [71:0] Sigma;
  logic [4:0]  L;
  logic        fail;
  logic        done;
  logic [2:0]  dbg_state;

  always #5 Clk = ~Clk;

  key_equation_solver dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .S_valid   (S_valid),
    .S_in      (S_in),
    .S_ready   (S_ready),
    .Sigma     (Sigma),
    .L         (L),
    .fail      (fail),
    .done      (done),
    .dbg_state (dbg_state)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;
  logic [77:0] exp_q[$];        // {sigma[71:0], L[4:0], fail}
  int unsigned acc_q[$];        // cycle stamp of the edge accepting S_16
  logic [7:0]  cur_s [16];
  int          exp_t [256];
  int          log_t [256];
  logic        prev_done = 1'b0;
  logic [77:0] mon_e;
  int unsigned mon_a;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // ---------------- reference model ----------------
  function automatic void init_tables();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    log_t[0] = 0;
  endfunction

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  function automatic logic [77:0] model_bm();
    int lam[9];
    int bb[9];
    int nl[9];
    int gam, ll, d;
    logic [77:0] res;
    for (int i = 0; i < 9; i++) begin
      lam[i] = (i == 0) ? 1 : 0;
      bb[i]  = (i == 0) ? 1 : 0;
    end
    gam = 1;
    ll  = 0;
    for (int r = 0; r < 16; r++) begin
      d = 0;
      for (int i = 0; i < 9; i++)
        if (r - i >= 0) d = d ^ gmul(lam[i], int'(cur_s[r - i]));
      for (int i = 0; i < 9; i++)
        nl[i] = gmul(gam, lam[i]) ^ ((i > 0) ? gmul(d, bb[i - 1]) : 0);
      if (d != 0 && 2 * ll <= r) begin
        bb  = lam;
        ll  = r + 1 - ll;
        gam = d;
      end else begin
        for (int i = 8; i > 0; i--) bb[i] = bb[i - 1];
        bb[0] = 0;
      end
      lam = nl;
    end
    res = '0;
    for (int i = 0; i < 9; i++) res[6 + 8*i +: 8] = 8'(lam[i]);
    res[5:1] = 5'(ll);
    res[0]   = (ll > 8);
    return res;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin
    if (!Reset) begin
      if (prev_done) check("done_one_cycle", done, 1'b0);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1 expected no result pending");
        end else begin
          mon_e = exp_q.pop_front();
          check("sigma", Sigma, mon_e[77:6]);
          check("L",     L,     mon_e[5:1]);
          check("fail",  fail,  mon_e[0]);
          if (acc_q.size() > 0) begin
            mon_a = acc_q.pop_front();
            check("latency", cyc - mon_a, LAT);
          end
        end
      end
    end
    prev_done <= done && !Reset;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit gaps, input bit hold, input bit track);
    bit acc;
    int g;
    for (int k = 0; k < 16; k++) begin
      g = gaps ? $urandom_range(0, 3) : 0;
      if (g > 0) begin
        S_valid = 1'b0;
        S_in    = 8'($urandom);
        repeat (g) begin @(posedge Clk); #1; end
      end
      S_valid = 1'b1;
      S_in    = cur_s[k];
      acc     = 1'b0;
      for (int w = 0; w < 50 && !acc; w++) begin
        @(negedge Clk);
        acc = S_ready;
        @(posedge Clk); #1;
      end
      if (!acc) begin
        n_checks++;
        $display("FAIL load_timeout: got S_ready=0 expected 1 at byte %0d", k);
      end
    end
    if (track) acc_q.push_back(cyc);
    if (hold) begin
      for (int k = 0; k < 20; k++) begin
        S_in = 8'($urandom);
        @(negedge Clk);
        check("ready_low_busy", S_ready, 1'b0);
        @(posedge Clk); #1;
      end
    end
    S_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge Clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL done_timeout: got no done expected one within 100 cycles");
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge Clk); #1;
  endtask

  task automatic run_vec(input bit gaps, input bit hold, input logic [77:0] expv);
    exp_q.push_back(expv);
    send(gaps, hold, 1'b1);
    wait_done();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nerr, pos, ev, sj;
    init_tables();
    Reset   = 1'b1;
    S_valid = 1'b0;
    S_in    = 8'h00;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_sigma", Sigma, 72'h0);
    check("reset_L",     L,     5'd0);
    check("reset_fail",  fail,  1'b0);
    check("reset_done",  done,  1'b0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("ready_after_reset", S_ready, 1'b1);
    check("idle_after_reset",  dbg_state, IDLE);
    @(posedge Clk); #1;

    // All-zero syndromes: no errors.
    for (int k = 0; k < 16; k++) cur_s[k] = 8'h00;
    run_vec(1'b0, 1'b0, {56'h0, 8'h00, 8'h01, 5'd0, 1'b0});

    // All-ones: error value 1 at position 0.
    for (int k = 0; k < 16; k++) cur_s[k] = 8'h01;
    run_vec(1'b0, 1'b0, {56'h0, 8'h01, 8'h01, 5'd1, 1'b0});

    // S_i = alpha^i: error at position 1, locator scaled by alpha^15.
    for (int k = 0; k < 16; k++) cur_s[k] = 8'(exp_t[k + 1]);
    run_vec(1'b0, 1'b0, {56'h0, 8'h4C, 8'h26, 5'd1, 1'b0});

    // Only S_16 nonzero: degree 16, uncorrectable.
    for (int k = 0; k < 16; k++) cur_s[k] = (k == 15) ? 8'h01 : 8'h00;
    run_vec(1'b0, 1'b0, {56'h0, 8'h00, 8'h01, 5'd16, 1'b1});

    // Same alpha vector with random gaps and S_valid held high while busy.
    for (int k = 0; k < 16; k++) cur_s[k] = 8'(exp_t[k + 1]);
    run_vec(1'b1, 1'b1, {56'h0, 8'h4C, 8'h26, 5'd1, 1'b0});

    // Reset in the middle of iteration r=7.
    send(1'b0, 1'b0, 1'b0);
    repeat (14) @(posedge Clk);
    #1;
    check("mid_iter_state", dbg_state, DISC);
    Reset = 1'b1;
    @(negedge Clk);
    check("midreset_sigma", Sigma, 72'h0);
    check("midreset_L",     L,     5'd0);
    check("midreset_fail",  fail,  1'b0);
    check("midreset_done",  done,  1'b0);
    check("midreset_state", dbg_state, IDLE);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("midreset_ready", S_ready, 1'b1);
    @(posedge Clk); #1;
    for (int k = 0; k < 16; k++) cur_s[k] = 8'h01;
    run_vec(1'b1, 1'b0, {56'h0, 8'h01, 8'h01, 5'd1, 1'b0});

    // Randomized: raw random syndromes and syndromes of 1..4 random errors.
    for (int n = 0; n < 10; n++) begin
      if (n % 2 == 0) begin
        for (int k = 0; k < 16; k++) cur_s[k] = 8'($urandom);
      end else begin
        for (int k = 0; k < 16; k++) cur_s[k] = 8'h00;
        nerr = $urandom_range(1, 4);
        for (int e = 0; e < nerr; e++) begin
          pos = $urandom_range(0, 254);
          ev  = $urandom_range(1, 255);
          for (int j = 1; j <= 16; j++) begin
            sj = gmul(ev, exp_t[(j * pos) % 255]);
            cur_s[j - 1] = cur_s[j - 1] ^ 8'(sj);
          end
        end
      end
      run_vec(n % 3 == 0, n % 4 == 1, model_bm());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

endmodule
